// File: rtl/dm_port_arbiter_if.sv
// Requester-side handshake bundle for dm_port_arbiter.
// The requester drives through 'master'; the arbiter drives through 'slave'.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter that serialises 64-bit requester accesses into eight
// big-endian byte beats on a byte-wide data memory.
module dm_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  dm_port_arbiter_if.slave  p0,
  dm_port_arbiter_if.slave  p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        beat;
  logic              gnt;
  logic              last_grant;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic [DATA_W-1:0] wdata_shift;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              any_req;
  logic              gnt_next;
  logic              ack0;
  logic              ack1;

  // On a tie the port that did not win last time goes next.
  assign any_req  = p0.req | p1.req;
  assign gnt_next = (p0.req & p1.req) ? ~last_grant : p1.req;
  assign rd_next  = {rd_sh[DATA_W-9:0], mem_rdata};

  assign p0.ack   = ack0;
  assign p1.ack   = ack1;
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Memory strobes are decoded from state so a reset drops mem_we at once.
  always_comb begin
    state_next  = state;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    busy        = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    wdata_shift = wdata_lat << {beat, 3'b000};
    case (state)
      IDLE: begin
        if (any_req) state_next = XFER;
      end
      XFER: begin
        busy     = 1'b1;
        mem_addr = addr_lat + ADDR_W'(beat);
        mem_we   = we_lat;
        if (we_lat) mem_wdata = wdata_shift[DATA_W-1 -: 8];
        if (beat == 3'd7) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        ack0       = ~gnt;
        ack1       = gnt;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      we_lat     <= 1'b0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      rd_sh      <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= gnt_next;
            last_grant <= gnt_next;
            beat       <= '0;
            we_lat     <= gnt_next ? p1.we    : p0.we;
            addr_lat   <= gnt_next ? p1.addr  : p0.addr;
            wdata_lat  <= gnt_next ? p1.wdata : p0.wdata;
          end
        end
        XFER: begin
          beat <= beat + 3'd1;
          if (!we_lat) begin
            rd_sh <= rd_next;
            // Capture the completed word so it is already valid during DONE.
            if (beat == 3'd7) begin
              if (gnt) rdata1 <= rd_next;
              else     rdata0 <= rd_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a byte-wide
// behavioural memory that the bench can also preload.
module tb_dm_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic [7:0]        mem [0:255];
  logic              tb_we = 1'b0;
  logic [7:0]        tb_addr = '0;
  logic [7:0]        tb_data = '0;
  int                checks = 0;
  int                errors = 0;

  dm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0 ();
  dm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1 ();

  dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .p0        (p0),
    .p1        (p1),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Byte memory: DUT writes take priority over bench preloads.
  always @(posedge clock) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pokeMem(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  // Issues one transaction from an IDLE cycle and returns one cycle later in IDLE.
  task automatic applyStimulus(input int port, input string tag, input logic we,
                               input logic [7:0] addr, input logic [63:0] wdata,
                               output int lat, output logic [63:0] rdata,
                               output logic other_ack);
    if (port == 0) begin
      p0.we = we; p0.addr = addr; p0.wdata = wdata; p0.req = 1'b1;
    end else begin
      p1.we = we; p1.addr = addr; p1.wdata = wdata; p1.req = 1'b1;
    end
    lat = 0;
    rdata = '0;
    other_ack = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock);
      #1;
      if ((port == 0 && p1.ack) || (port == 1 && p0.ack)) other_ack = 1'b1;
      if ((port == 0 && p0.ack) || (port == 1 && p1.ack)) begin
        lat = i;
        rdata = (port == 0) ? p0.rdata : p1.rdata;
        break;
      end
    end
    if (port == 0) p0.req = 1'b0;
    else           p1.req = 1'b0;
    checkOutput({tag, "_ack_seen"}, 64'(lat != 0), 64'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int          lat;
    int          n;
    int          cyc;
    int          ord [4];
    int          at [4];
    logic [63:0] rd;
    logic        oth;

    p0.req = 1'b0; p0.we = 1'b0; p0.addr = '0; p0.wdata = '0;
    p1.req = 1'b0; p1.we = 1'b0; p1.addr = '0; p1.wdata = '0;

    for (int i = 0; i < 256; i++) pokeMem(8'(i), 8'h00);
    for (int i = 8; i < 16; i++) pokeMem(8'(i), 8'h11);
    for (int i = 32; i < 40; i++) pokeMem(8'(i), 8'h5A);

    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_acks", 64'({p0.ack, p1.ack}), 64'd0);
    checkOutput("rst_rdata0", p0.rdata, 64'd0);

    @(posedge clock);
    #1 reset_n = 1'b1;

    // Read of a uniform block
    applyStimulus(0, "t1", 1'b0, 8'h08, 64'd0, lat, rd, oth);
    checkOutput("t1_latency", 64'(lat), 64'd9);
    checkOutput("t1_rdata", rd, 64'h1111111111111111);
    checkOutput("t1_p1_ack", 64'(oth), 64'd0);

    // Big-endian write then read back
    applyStimulus(1, "t2w", 1'b1, 8'h10, 64'h0123456789ABCDEF, lat, rd, oth);
    checkOutput("t2_latency", 64'(lat), 64'd9);
    checkOutput("t2_mem10", 64'(mem[8'h10]), 64'h01);
    checkOutput("t2_mem13", 64'(mem[8'h13]), 64'h67);
    checkOutput("t2_mem17", 64'(mem[8'h17]), 64'hEF);
    checkOutput("t2_p1_rdata_kept", p1.rdata, 64'd0);
    applyStimulus(0, "t2r", 1'b0, 8'h10, 64'd0, lat, rd, oth);
    checkOutput("t2_rdata", rd, 64'h0123456789ABCDEF);
    checkOutput("t2_rdata_held", p0.rdata, 64'h0123456789ABCDEF);

    // Address wrap across 0xFF
    applyStimulus(0, "t4w", 1'b1, 8'hFC, 64'hA1A2A3A4A5A6A7A8, lat, rd, oth);
    checkOutput("t4_memFC", 64'(mem[8'hFC]), 64'hA1);
    checkOutput("t4_memFF", 64'(mem[8'hFF]), 64'hA4);
    checkOutput("t4_mem00", 64'(mem[8'h00]), 64'hA5);
    checkOutput("t4_mem03", 64'(mem[8'h03]), 64'hA8);
    checkOutput("t4_p0_rdata_kept", p0.rdata, 64'h0123456789ABCDEF);
    applyStimulus(1, "t4r", 1'b0, 8'hFC, 64'd0, lat, rd, oth);
    checkOutput("t4_rdata", rd, 64'hA1A2A3A4A5A6A7A8);

    // Reset during write beat 3
    p0.we = 1'b1; p0.addr = 8'h20; p0.wdata = 64'hC0C1C2C3C4C5C6C7; p0.req = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("t5_beat3_we", 64'(mem_we), 64'd1);
    checkOutput("t5_beat3_addr", 64'(mem_addr), 64'h23);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_we_drop", 64'(mem_we), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    p0.req = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("t5_no_ack", 64'(p0.ack), 64'd0);
    checkOutput("t5_mem20", 64'(mem[8'h20]), 64'hC0);
    checkOutput("t5_mem22", 64'(mem[8'h22]), 64'hC2);
    checkOutput("t5_mem23", 64'(mem[8'h23]), 64'h5A);
    checkOutput("t5_mem27", 64'(mem[8'h27]), 64'h5A);

    // Request dropped mid-read still completes
    p1.we = 1'b0; p1.addr = 8'h08; p1.req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t6_busy", 64'(busy), 64'd1);
    checkOutput("t6_beat2_addr", 64'(mem_addr), 64'h0A);
    p1.req = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (p1.ack) begin
        n = i;
        break;
      end
    end
    checkOutput("t6_ack_delay", 64'(n), 64'd6);
    checkOutput("t6_rdata", p1.rdata, 64'h1111111111111111);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t6_idle_busy", 64'(busy), 64'd0);
    checkOutput("t6_idle_acks", 64'({p0.ack, p1.ack}), 64'd0);

    // Both requests held high from reset alternate p0, p1, p0, p1
    reset_n = 1'b0;
    p0.we = 1'b0; p0.addr = 8'h10; p0.req = 1'b1;
    p1.we = 1'b0; p1.addr = 8'hFC; p1.req = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ord[i] = -1;
      at[i] = 0;
    end
    for (cyc = 1; cyc <= 60 && n < 4; cyc++) begin
      @(posedge clock);
      #1;
      if (p0.ack) begin ord[n] = 0; at[n] = cyc; n++; end
      if (p1.ack && n < 4) begin ord[n] = 1; at[n] = cyc; n++; end
    end
    p0.req = 1'b0;
    p1.req = 1'b0;
    checkOutput("t3_ack_count", 64'(n), 64'd4);
    checkOutput("t3_order", 64'({ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]}), 64'b00010001);
    checkOutput("t3_first_ack", 64'(at[0]), 64'd9);
    checkOutput("t3_p1_wait", 64'(at[1] - at[0]), 64'd10);
    checkOutput("t3_spacing", 64'(at[3] - at[2]), 64'd10);
    checkOutput("t3_p0_rdata", p0.rdata, 64'h0123456789ABCDEF);
    checkOutput("t3_p1_rdata", p1.rdata, 64'hA1A2A3A4A5A6A7A8);
    @(posedge clock);
    #1;
    checkOutput("t3_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
